// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: the active-high
// segment table (bit 6 = a ... bit 0 = g), the blank pattern and the per-digit record.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b111_1110,  // 0
    7'b011_0000,  // 1
    7'b110_1101,  // 2
    7'b111_1001,  // 3
    7'b011_0011,  // 4
    7'b101_1011,  // 5
    7'b101_1111,  // 6
    7'b111_0000,  // 7
    7'b111_1111,  // 8
    7'b111_1011,  // 9
    7'b111_0111,  // A
    7'b001_1111,  // b
    7'b100_1110,  // C
    7'b011_1101,  // d
    7'b100_1111,  // E
    7'b100_0111   // F
  };

  typedef struct packed {
    logic [3:0] value;
    logic       enable;
    logic       dp;
  } digit_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-high seven-segment decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver with staged, tear-free display updates
// that take effect only at the frame wrap.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digit_values,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  input  logic [NUM_DIGITS-1:0]   dp_values,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  // Output level that means "off"; XOR-ing with it applies the polarity.
  localparam logic OFF = (ACTIVE_LOW != 0);

  logic [PW-1:0] prescale;
  logic [IW-1:0] scan_idx;
  logic          load_pending;
  digit_t [NUM_DIGITS-1:0] staging;
  digit_t [NUM_DIGITS-1:0] display;
  digit_t [NUM_DIGITS-1:0] incoming;

  logic tick;
  logic wrap;
  digit_t cur;
  logic [6:0] seg_raw;
  logic [NUM_DIGITS-1:0] anode_on;
  logic [6:0] seg_on;
  logic dp_on;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      incoming[i].value  = digit_values[4*i +: 4];
      incoming[i].enable = digit_enable[i];
      incoming[i].dp     = dp_values[i];
    end
  end

  assign tick = (prescale == PRE_LAST);
  assign wrap = tick && (scan_idx == IDX_LAST);
  assign cur  = display[scan_idx];

  hex_to_seg u_hex_to_seg (
    .nibble   (cur.value),
    .segments (seg_raw)
  );

  // A disabled digit keeps its anode off as well as its segments.
  always_comb begin
    anode_on = '0;
    seg_on   = SEG_BLANK;
    dp_on    = 1'b0;
    if (cur.enable) begin
      anode_on = NUM_DIGITS'(1) << scan_idx;
      seg_on   = seg_raw;
      dp_on    = cur.dp;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prescale     <= '0;
      scan_idx     <= '0;
      load_pending <= 1'b0;
      staging      <= '0;
      display      <= '0;
      frame_done   <= 1'b0;
      anode        <= {NUM_DIGITS{OFF}};
      cathode      <= {7{OFF}};
      dp           <= OFF;
    end else begin
      frame_done <= wrap;

      if (tick) begin
        prescale <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        prescale <= prescale + 1'b1;
      end

      if (load) staging <= incoming;

      // A load landing on the wrap bypasses staging so it is shown next frame.
      if (load && wrap) begin
        display      <= incoming;
        load_pending <= 1'b0;
      end else if (wrap && load_pending) begin
        display      <= staging;
        load_pending <= 1'b0;
      end else if (load) begin
        load_pending <= 1'b1;
      end

      anode   <= anode_on ^ {NUM_DIGITS{OFF}};
      cathode <= seg_on ^ {7{OFF}};
      dp      <= dp_on ^ OFF;
    end
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL provide parameter REFRESH_DIV, default 100000, clock cycles each digit is lit (>=2).
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1; 1 means anode/cathode/dp are driven low to light.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 clock  input  1  sole clock, all state on rising edge.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 digit_values  input  4*NUM_DIGITS  hex nibble per digit; digit i at [4i+3:4i]; digit 0 is rightmost.
REQ-008 digit_enable  input  NUM_DIGITS  per-digit enable; 0 blanks that digit.
REQ-009 dp_values  input  NUM_DIGITS  per-digit decimal point request.
REQ-010 load  input  1  one-cycle strobe capturing digit_values/digit_enable/dp_values into the staging register.
REQ-011 anode  output  NUM_DIGITS  digit select, exactly one active or none.
REQ-012 cathode  output  7  segments, cathode[6]=a ... cathode[0]=g.
REQ-013 dp  output  1  decimal point segment.
REQ-014 frame_done  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

Function
REQ-015 SHALL hold a prescaler counting 0..REFRESH_DIV-1; terminal count returns it to 0 and advances scan index.
REQ-016 Scan index SHALL count 0..NUM_DIGITS-1 and wrap to 0; frame_done SHALL assert in the cycle the wrap is registered.
REQ-017 SHALL hold staging and display (shadow) registers for values, enables, dp; only the display register drives outputs.
REQ-018 load SHALL write staging and set load_pending; a second load before the wrap SHALL overwrite staging (latest wins).
REQ-019 On frame wrap with load_pending=1, display SHALL take staging and load_pending SHALL clear; no mid-frame display change (tear-free).
REQ-020 load in the same cycle as a wrap SHALL transfer the incoming inputs directly to display and leave load_pending=0.
REQ-021 anode, cathode, dp SHALL be registered; they reflect the scan index and display register with 1-cycle latency.
REQ-022 Segment encoding SHALL be active-high internally (a..g) for 0-F, inverted at the output when ACTIVE_LOW=1; e.g. "1" = 7'b1001111, "2" = 7'b0010010 active-low.
REQ-023 A disabled digit SHALL drive its anode inactive and cathode/dp all-off; the scan still spends REFRESH_DIV cycles on it.
REQ-024 Only the anode bit equal to the registered scan index SHALL ever be active; never two simultaneously.
REQ-025 Index width SHALL be $clog2(NUM_DIGITS), prescaler width $clog2(REFRESH_DIV); no truncation warnings.

Reset
REQ-026 While reset_n=0 at a clock edge: prescaler=0, index=0, load_pending=0, staging/display registers=0, frame_done=0.
REQ-027 During and after reset, all anodes, all cathodes and dp SHALL be inactive until the first post-reset registered update.
REQ-028 Reset asserted mid-frame SHALL abort the frame and discard any pending load; no frame_done pulse is generated.

Structure
REQ-029 Package seg_pkg SHALL hold the 16-entry active-high segment pattern table, SEG_BLANK constant and the per-digit record typedef (value, enable, dp).
REQ-030 Sub-module hex_to_seg (combinational nibble-to-7-segment decoder) SHALL be instantiated once after the digit mux.

Verification
REQ-031 NUM_DIGITS=4, REFRESH_DIV=4, release reset -> anode=4'b1111, cathode=7'b1111111 until first update; then anode cycles 1110,1101,1011,0111 every 4 cycles.
REQ-032 load with values 0x4321, enable=4'b1111 mid-frame -> display unchanged until wrap; next frame digit0 cathode=7'b1001111, digit1 =7'b0010010.
REQ-033 Two loads (0x1111 then 0x2222) within one frame -> next frame shows 0x2222 only.
REQ-034 load coincident with wrap cycle -> new values visible on digit 0 of the immediately following frame; frame_done single-cycle pulse every 16 cycles.
REQ-035 enable=4'b1010 -> anodes 0 and 2 stay inactive with cathode=7'b1111111 during their slots; timing of digits 1, 3 unchanged.
REQ-036 reset_n low for 1 cycle at index 2 with load pending -> outputs blank, index 0, pending load discarded, no frame_done.
